// File: rtl/vwb_drain_if.sv
// vwb_drain_if: result-vector handoff from execute and element write port toward the register file
interface vwb_drain_if;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_vreg;
  logic [4:0]   in_len;
  logic [255:0] in_data;
  logic         wEn;
  logic [3:0]   wAddr;
  logic [3:0]   wInd;
  logic [15:0]  wData;
  logic         done;
  logic [3:0]   done_vreg;
  logic         busy;
  modport slave (
    input  in_valid, in_vreg, in_len, in_data,
    output in_ready, wEn, wAddr, wInd, wData, done, done_vreg, busy
  );
  modport master (
    output in_valid, in_vreg, in_len, in_data,
    input  in_ready, wEn, wAddr, wInd, wData, done, done_vreg, busy
  );
endinterface

// File: rtl/vwb_drain.sv
// vwb_drain: buffers result vectors in a small FIFO and writes them into the register file one element per cycle
module vwb_drain #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  vwb_drain_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t        st;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [3:0]    idx;
  logic [3:0]    vregQ [DEPTH];
  logic [4:0]    lenQ  [DEPTH];
  logic [255:0]  dataQ [DEPTH];
  logic          push, pop, last, drain;
  logic [4:0]    hLen;
  assign hLen  = lenQ[head];
  assign drain = st == DRAIN;
  assign last  = {1'b0, idx} == hLen - 5'd1;
  assign push  = bus.in_valid && bus.in_ready;
  // a zero-length entry retires in its first cycle without touching the write port
  assign pop   = drain && (hLen == 5'd0 || last);
  assign bus.in_ready  = count < (AW+1)'(DEPTH);
  assign bus.busy      = count != '0;
  assign bus.wEn       = drain && hLen != 5'd0;
  assign bus.wAddr     = bus.wEn ? vregQ[head] : 4'd0;
  assign bus.wInd      = bus.wEn ? idx : 4'd0;
  assign bus.wData     = bus.wEn ? dataQ[head][{idx, 4'b0000} +: 16] : 16'd0;
  assign bus.done      = pop;
  assign bus.done_vreg = pop ? vregQ[head] : 4'd0;
  always_ff @(posedge clk)
    if (push) begin
      vregQ[tail] <= bus.in_vreg;
      lenQ[tail]  <= bus.in_len > 5'd16 ? 5'd16 : bus.in_len;
      dataQ[tail] <= bus.in_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      idx   <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      idx   <= pop ? 4'd0 : bus.wEn ? idx + 4'd1 : idx;
      st    <= st == IDLE ? (push ? DRAIN : IDLE)
                          : (pop && !push && count == (AW+1)'(1) ? IDLE : DRAIN);
    end
endmodule

// File: tb/tb_vwb_drain.sv
// tb_vwb_drain: directed scoreboard bench; every cycle the outputs must equal the next expected port event
module tb_vwb_drain;
  typedef struct packed {
    logic        we;
    logic [3:0]  a;
    logic [3:0]  i;
    logic [15:0] d;
    logic        dn;
    logic [3:0]  dv;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n;
  vwb_drain_if bus();
  vwb_drain #(.DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  ev_t q[$];
  int  mcnt = 0;
  int  nAsserts = 0;
  int  nFails = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic sample();
    ev_t o, e;
    o = {bus.wEn, bus.wAddr, bus.wInd, bus.wData, bus.done, bus.done_vreg};
    e = (q.size() != 0) ? q[0] : '0;
    chk("port", 64'(o), 64'(e));
    chk("busy", 64'(bus.busy), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(mcnt < 2));
    if (q.size() != 0) begin
      if (q[0].dn) mcnt--;
      void'(q.pop_front());
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    sample();
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) cyc();
  endtask
  task automatic offer(input logic [3:0] v, input logic [4:0] len, input logic [255:0] dat);
    int  k, L;
    ev_t e;
    bus.in_valid = 1'b1;
    bus.in_vreg  = v;
    bus.in_len   = len;
    bus.in_data  = dat;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      cyc();
      k++;
    end
    chk("accept_timeout", 64'(k < 100), 64'd1);
    L = (len > 5'd16) ? 16 : int'(len);
    if (L == 0) begin
      e = '0;
      e.dn = 1'b1;
      e.dv = v;
      q.push_back(e);
    end else
      for (int i = 0; i < L; i++) begin
        e = '0;
        e.we = 1'b1;
        e.a  = v;
        e.i  = 4'(i);
        e.d  = dat[16*i +: 16];
        e.dn = (i == L - 1);
        e.dv = (i == L - 1) ? v : 4'd0;
        q.push_back(e);
      end
    mcnt++;
    cyc();
    bus.in_valid = 1'b0;
  endtask
  function automatic logic [255:0] seqd(input int base);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = 16'(base + i);
    return r;
  endfunction
  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vreg  = '0;
    bus.in_len   = '0;
    bus.in_data  = '0;
    @(negedge clk);
    sample();
    rst_n = 1'b1;
    cyc();
    offer(4'd3, 5'd16, seqd(0));
    idle(18);
    chk("t1_drained", 64'(q.size()), 64'd0);
    offer(4'd1, 5'd4, rnd());
    offer(4'd5, 5'd2, rnd());
    idle(8);
    offer(4'd10, 5'd16, rnd());
    offer(4'd11, 5'd16, rnd());
    offer(4'd12, 5'd16, rnd());
    idle(40);
    chk("t3_drained", 64'(q.size()), 64'd0);
    offer(4'd2, 5'd2, rnd());
    offer(4'd7, 5'd0, rnd());
    offer(4'd4, 5'd2, rnd());
    idle(8);
    offer(4'd9, 5'd20, rnd());
    idle(20);
    chk("t5_drained", 64'(q.size()), 64'd0);
    offer(4'd6, 5'd16, rnd());
    offer(4'd8, 5'd3, rnd());
    repeat (4) cyc();
    chk("pre_reset_idx", 64'(bus.wInd), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_port", 64'({bus.wEn, bus.wAddr, bus.wInd, bus.wData, bus.done, bus.done_vreg}), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    q.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule

// File: doc/vwb_drain.md
# vwb_drain

Vector writeback drain stage: accepts whole 256-bit result vectors (16 × 16-bit elements) from the vector execute stage and writes them into the vector register file one element per cycle through its single element write port. Sits directly upstream of the vector register file. Decouples the execute stage with a small FIFO of pending result vectors, so execute can hand off a result and continue while earlier results are still draining.

## Interface
- DEPTH, 2, number of pending result vectors buffered; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  result vector offered
- in_ready  out  1  stage can accept a vector this cycle
- in_vreg  in  4  destination vector register
- in_len  in  5  element count, 0..16; values >16 are clamped to 16
- in_data  in  256  element i at bits [16i+15:16i]
- wEn  out  1  element write enable to register file
- wAddr  out  4  destination register of current element
- wInd  out  4  element index being written
- wData  out  16  element value
- done  out  1  pulses in the cycle a vector retires
- done_vreg  out  4  register of the retiring vector; valid when done=1
- busy  out  1  FIFO non-empty

## Operation
- Storage: DEPTH-entry circular FIFO of {vreg, len (clamped), data}, head/tail pointers, count register (0..DEPTH), element index register idx (0..15).
- Push: in_valid && in_ready at rising edge writes entry at tail; tail wraps at DEPTH.
- in_ready = (count < DEPTH); depends only on registered state, never on in_valid. No pass-through when full, even if a pop occurs the same cycle.
- FSM states: IDLE (count==0), DRAIN (count>0). IDLE→DRAIN when count becomes nonzero; DRAIN→IDLE when the last entry pops with no simultaneous push.
- In DRAIN with head len>0: wEn=1, wAddr=head.vreg, wInd=idx, wData=head.data[16·idx+:16]; idx increments each cycle.
- Retire: when idx==len−1, done=1, done_vreg=head.vreg in that same cycle; at edge head advances, count decrements, idx resets to 0.
- len==0 entry: retires in one cycle with wEn=0, done=1, no register writes.
- Simultaneous push and retire: count unchanged; both pointers advance.
- Elements are written in ascending index order; vectors retire in acceptance order.
- Outputs in IDLE: wEn=0, done=0; wAddr/wInd/wData/done_vreg driven 0.

## Timing
- Reset (async assert, any state): count=0, head=tail=0, idx=0, FSM=IDLE; in_ready=1, busy=0, wEn=0, done=0, wAddr=wInd=0, wData=0, done_vreg=0. Reset mid-drain abandons remaining elements; elements already written stay in the register file.
- Latency: vector accepted at edge N → first element write (wEn=1) in cycle N+1; vector of length L occupies write port cycles N+1..N+L; done in cycle N+L.
- Throughput: back-to-back vectors drain with no bubble; port sustained at one element/cycle while busy.
- Register file commits each write at the edge ending the cycle wEn is asserted.
- busy = (count != 0); high from cycle after first acceptance until after the edge retiring the last entry.

## Test plan
- Reset then push {vreg=3, len=16, data=elements 0x0000..0x000F}: wEn high 16 cycles, wInd 0..15, wData 0x0000..0x000F, wAddr=3; done with done_vreg=3 on the 16th cycle; busy low after.
- Push len=4 to v1 then len=2 to v5 back-to-back: 6 consecutive write cycles, no gap; done pulses at cycles 4 and 6 with done_vreg 1 then 5.
- Push 3 vectors of len=16 with in_valid held: third held (in_ready=0) until first retires; in_ready returns 1 the cycle after first done; all 48 elements written in order.
- Push len=0 to v7 between two len=2 vectors: single cycle with wEn=0, done=1, done_vreg=7; no write to v7.
- Push len=20: exactly 16 writes, wInd 0..15.
- Assert rst_n=0 mid-vector at idx=5 with second entry queued: outputs go to reset values immediately; after release in_ready=1, busy=0, no further writes.
